pc_sequencer: RTL and testbench

//   Fetch sequencer for the single-cycle CPU. Owns the architectural PC and drives it into

---
 rtl/pc_seq_pkg.sv | 18 +
 rtl/pc_next_mux.sv | 47 ++++
 rtl/pc_sequencer.sv | 102 ++++++++++
 tb/tb_pc_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the fetch sequencer.
// FSM state encoding plus the default vectors and fetch width.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } pc_state_t;

  localparam int          DEF_ADDR_W      = 32;
  localparam logic [31:0] DEF_RESET_VEC   = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC    = 32'h0000_0100;
  localparam int          DEF_INSTR_BYTES = 4;
  localparam int          ALIGN_BITS      = 2;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC select: jump > branch > sequential, with alignment handling.
// Build option PC_SEQ_MISALIGN_TRAP_EN sends misaligned redirects to TRAP_VEC.
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                INSTR_BYTES = DEF_INSTR_BYTES,
  parameter logic [ADDR_W-1:0] TRAP_VEC    = ADDR_W'(DEF_TRAP_VEC)
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc_next,
  output logic              redirect_sel,
  output logic              trap_hit
);

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] target_aligned;
  logic              misaligned;

  // Wraps naturally modulo 2^ADDR_W.
  assign pc_seq         = pc + ADDR_W'(INSTR_BYTES);
  assign target         = jump ? jump_target : branch_target;
  assign redirect_sel   = jump || branch_taken;
  assign misaligned     = redirect_sel && (target[ALIGN_BITS-1:0] != '0);
  assign target_aligned = {target[ADDR_W-1:ALIGN_BITS], ALIGN_BITS'(0)};
  assign trap_hit       = TRAP_EN && misaligned;

  always_comb begin
    pc_next = pc_seq;
    if (trap_hit)
      pc_next = TRAP_VEC;
    else if (redirect_sel)
      pc_next = target_aligned;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: PC register, fetch handshake FSM, retired-fetch counter.
// Misaligned-redirect trapping is enabled by defining PC_SEQ_MISALIGN_TRAP_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] TRAP_VEC    = ADDR_W'(DEF_TRAP_VEC),
  parameter int                INSTR_BYTES = DEF_INSTR_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_ready,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] next_pc,
  output logic              imem_req,
  output logic              pc_valid,
  output logic              redirect,
  output logic              trap,
  output logic [1:0]        state,
  output logic [31:0]       fetch_count
);

  pc_state_t         state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [31:0]       count_reg;
  logic              redirect_reg;
  logic              trap_reg;

  logic [ADDR_W-1:0] pc_next;
  logic              redirect_sel;
  logic              trap_hit;
  logic              accept;

  pc_next_mux #(
    .ADDR_W      (ADDR_W),
    .INSTR_BYTES (INSTR_BYTES),
    .TRAP_VEC    (TRAP_VEC)
  ) u_next_mux (
    .pc            (pc_reg),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_next       (pc_next),
    .redirect_sel  (redirect_sel),
    .trap_hit      (trap_hit)
  );

  // Once in WAIT the request is held until the memory takes it; stall no longer matters.
  assign imem_req = ((state_reg == ST_FETCH) && !stall) || (state_reg == ST_WAIT);
  assign accept   = imem_req && imem_ready;

  assign pc_valid    = accept;
  assign next_pc     = pc_reg;
  assign state       = state_reg;
  assign fetch_count = count_reg;
  assign redirect    = redirect_reg;
  assign trap        = trap_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= RESET_VEC;
      count_reg    <= '0;
      redirect_reg <= 1'b0;
      trap_reg     <= 1'b0;
    end else begin
      redirect_reg <= accept && redirect_sel;
      trap_reg     <= accept && trap_hit;
      if (accept) begin
        pc_reg    <= pc_next;
        count_reg <= count_reg + 32'd1;
      end
      case (state_reg)
        ST_IDLE:  state_reg <= ST_FETCH;
        ST_FETCH: begin
          if (halt)
            state_reg <= ST_HALT;
          else if (imem_req && !imem_ready)
            state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_ready)
            state_reg <= halt ? ST_HALT : ST_FETCH;
        end
        ST_HALT: begin
          if (resume && !halt)
            state_reg <= ST_FETCH;
        end
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a queue of expected PCs per accepted fetch.
// Define PC_SEQ_MISALIGN_TRAP_EN on both RTL and bench to check the trap build.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        halt;
  logic        resume;

  logic [31:0] next_pc;
  logic        imem_req;
  logic        pc_valid;
  logic        redirect;
  logic        trap;
  logic [1:0]  state;
  logic [31:0] fetch_count;

  logic [31:0] next_pc2;
  logic        imem_req2;
  logic        pc_valid2;
  logic        redirect2;
  logic        trap2;
  logic [1:0]  state2;
  logic [31:0] fetch_count2;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  localparam logic [31:0] MIS_PC   = 32'h0000_0100;
  localparam logic [31:0] MIS_TRAP = 32'd1;
`else
  localparam logic [31:0] MIS_PC   = 32'h0000_0040;
  localparam logic [31:0] MIS_TRAP = 32'd0;
`endif

  pc_sequencer u_dut (
    .clk           (clk),
    .rst           (rst),
    .imem_ready    (imem_ready),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .halt          (halt),
    .resume        (resume),
    .next_pc       (next_pc),
    .imem_req      (imem_req),
    .pc_valid      (pc_valid),
    .redirect      (redirect),
    .trap          (trap),
    .state         (state),
    .fetch_count   (fetch_count)
  );

  // Second instance only exercises the wrap from a top-of-memory reset vector.
  pc_sequencer #(.RESET_VEC(32'hFFFF_FFFC)) u_wrap (
    .clk           (clk),
    .rst           (rst),
    .imem_ready    (imem_ready),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .halt          (halt),
    .resume        (resume),
    .next_pc       (next_pc2),
    .imem_req      (imem_req2),
    .pc_valid      (pc_valid2),
    .redirect      (redirect2),
    .trap          (trap2),
    .state         (state2),
    .fetch_count   (fetch_count2)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One accepted fetch: drive, push the expected PC, clock, pop and compare.
  task automatic accept(input logic j, input logic [31:0] jt, input logic b,
                        input logic [31:0] bt, input logic h, input logic [31:0] exp_pc);
    logic [31:0] want;
    imem_ready = 1'b1; stall = 1'b0;
    jump = j; jump_target = jt; branch_taken = b; branch_target = bt; halt = h;
    #1;
    chk("pc_valid_accept", 32'(pc_valid), 32'd1);
    exp_q.push_back(exp_pc);
    exp_cnt++;
    cyc();
    jump = 1'b0; branch_taken = 1'b0; halt = 1'b0; imem_ready = 1'b0; stall = 1'b1;
    want = exp_q.pop_front();
    chk("next_pc", next_pc, want);
    chk("fetch_count", fetch_count, 32'(exp_cnt));
    $display("fetch #%0d next_pc=%08h expected=%08h", exp_cnt, next_pc, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; imem_ready = 1'b0; stall = 1'b0; halt = 1'b0; resume = 1'b0;
    jump = 1'b0; jump_target = '0; branch_taken = 1'b0; branch_target = '0;

    // Reset
    cyc(); cyc();
    chk("rst_next_pc", next_pc, 32'h0);
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_pc_valid", 32'(pc_valid), 32'd0);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);
    chk("rst_wrap_pc", next_pc2, 32'hFFFF_FFFC);
    rst = 1'b1;
    cyc();
    chk("idle_to_fetch", 32'(state), 32'(ST_FETCH));

    // Sequential fetches; the wrap instance rolls over on the first one
    accept(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'd4);
    chk("wrap_to_zero", next_pc2, 32'h0);
    accept(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'd8);
    accept(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'd12);
    accept(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'd16);

    // Memory not ready: enter WAIT, hold PC, ignore stall
    stall = 1'b0; imem_ready = 1'b0;
    #1;
    chk("req_before_wait", 32'(imem_req), 32'd1);
    chk("no_valid_not_ready", 32'(pc_valid), 32'd0);
    cyc();
    chk("wait_state", 32'(state), 32'(ST_WAIT));
    stall = 1'b1;
    #1;
    chk("wait_req_under_stall", 32'(imem_req), 32'd1);
    cyc(); cyc();
    chk("wait_state_held", 32'(state), 32'(ST_WAIT));
    chk("wait_pc_held", next_pc, 32'd16);
    accept(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'd20);
    chk("wait_to_fetch", 32'(state), 32'(ST_FETCH));

    // Stall in FETCH suppresses the request even with memory ready
    imem_ready = 1'b1;
    #1;
    chk("stall_no_req", 32'(imem_req), 32'd0);
    chk("stall_no_valid", 32'(pc_valid), 32'd0);
    cyc();
    chk("stall_pc_held", next_pc, 32'd20);
    imem_ready = 1'b0;

    // Branch outside acceptance is ignored; jump beats branch
    branch_taken = 1'b1; branch_target = 32'h80;
    cyc();
    branch_taken = 1'b0;
    chk("branch_ignored_pc", next_pc, 32'd20);
    chk("branch_ignored_redir", 32'(redirect), 32'd0);
    accept(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h40);
    chk("jump_redirect", 32'(redirect), 32'd1);
    accept(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h44);
    chk("redirect_pulse_end", 32'(redirect), 32'd0);
    accept(1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 32'h80);
    chk("branch_redirect", 32'(redirect), 32'd1);
    accept(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h84);

    // Halt with an accepted fetch, then halt+resume, then resume
    accept(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h88);
    chk("halt_state", 32'(state), 32'(ST_HALT));
    imem_ready = 1'b1; stall = 1'b0;
    #1;
    chk("halt_no_req", 32'(imem_req), 32'd0);
    chk("halt_no_valid", 32'(pc_valid), 32'd0);
    cyc();
    chk("halt_hold_state", 32'(state), 32'(ST_HALT));
    chk("halt_hold_pc", next_pc, 32'h88);
    halt = 1'b1; resume = 1'b1;
    cyc();
    chk("halt_resume_both", 32'(state), 32'(ST_HALT));
    halt = 1'b0;
    cyc();
    resume = 1'b0; imem_ready = 1'b0; stall = 1'b1;
    chk("resume_state", 32'(state), 32'(ST_FETCH));
    chk("resume_pc", next_pc, 32'h88);
    chk("resume_count", fetch_count, 32'(exp_cnt));

    // Misaligned jump target
    accept(1'b1, 32'h42, 1'b0, 32'h0, 1'b0, MIS_PC);
    chk("misalign_trap", 32'(trap), MIS_TRAP);
    chk("misalign_redirect", 32'(redirect), 32'd1);

    // Reset in the middle of a WAIT
    stall = 1'b0; imem_ready = 1'b0;
    cyc();
    chk("pre_reset_wait", 32'(state), 32'(ST_WAIT));
    rst = 1'b0;
    cyc();
    chk("mid_wait_rst_state", 32'(state), 32'(ST_IDLE));
    chk("mid_wait_rst_pc", next_pc, 32'h0);
    chk("mid_wait_rst_req", 32'(imem_req), 32'd0);
    chk("mid_wait_rst_count", fetch_count, 32'd0);
    chk("mid_wait_rst_wrap_pc", next_pc2, 32'hFFFF_FFFC);
    rst = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
